// File: rtl/calc_seq_alu_pkg.sv
// Shared types and helpers for the sequential calculator ALU.
// Consumers: calc_seq_alu, calc_iter_unit.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bits needed to hold values 0..value-1; used to size the iteration counter.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        res = res + 1;
        rem = rem >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Bit-serial multiply/divide engine: one shared shift register, one W+2-bit adder
// and a down-counter. Mul is LSB-first shift-add, div is MSB-first restoring.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH + 1);

  logic [RW-1:0]    sh_r;
  logic [RW-1:0]    sh_nxt_s;
  logic [WIDTH-1:0] opnd_r;
  logic             div_r;
  logic             busy_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   add_a_s;
  logic [WIDTH:0]   add_b_s;
  logic             add_cin_s;
  logic [WIDTH+1:0] sum_s;

  // Shared adder: mul adds the multiplicand to the high half, div subtracts the
  // divisor from the shifted partial remainder; the top carry means "no borrow".
  always_comb begin
    add_a_s   = {1'b0, sh_r[RW-1:WIDTH]};
    add_b_s   = {1'b0, opnd_r};
    add_cin_s = 1'b0;
    if (div_r) begin
      add_a_s   = sh_r[RW-1:WIDTH-1];
      add_b_s   = ~{1'b0, opnd_r};
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, sh_r[RW-1:WIDTH]};
    end
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH + 1){1'b0}}, add_cin_s};

    sh_nxt_s = sh_r;
    if (div_r) begin
      if (sum_s[WIDTH+1]) begin
        sh_nxt_s = {sum_s[WIDTH-1:0], sh_r[WIDTH-2:0], 1'b1};
      end else begin
        sh_nxt_s = {sh_r[RW-2:0], 1'b0};
      end
    end else if (sh_r[0]) begin
      sh_nxt_s = {sum_s[WIDTH:0], sh_r[WIDTH-1:1]};
    end else begin
      sh_nxt_s = {1'b0, sh_r[RW-1:1]};
    end
  end

  // The final step's value is handed out combinationally so the top can
  // register it on the same edge the counter reaches zero.
  assign done   = busy_r && (cnt_r == CW'(1));
  assign result = sh_nxt_s;

  // Load on start, then step once per cycle until the counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r   <= {RW{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      div_r  <= 1'b0;
      busy_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (start) begin
      sh_r   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      opnd_r <= is_div ? b : a;
      div_r  <= is_div;
      busy_r <= 1'b1;
      cnt_r  <= CW'(WIDTH);
    end else if (busy_r) begin
      sh_r  <= sh_nxt_s;
      cnt_r <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_seq_alu.sv
// Clocked calculator ALU: single-cycle add/sub, bit-serial mul/div, valid/ready in and out.
// Optional accumulator operand (acc_sel) is built when CALC_SEQ_ALU_ACC_EN is defined.
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int RW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
`ifdef CALC_SEQ_ALU_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    o,
  output logic             neg,
  output logic             err
);

  state_e           state_r;
  op_e              op_s;
  logic [WIDTH-1:0] a_s;
  logic             accept_s;
  logic             start_s;
  logic             is_div_s;
  logic             iter_done_s;
  logic [RW-1:0]    iter_result_s;
`ifdef CALC_SEQ_ALU_ACC_EN
  logic [WIDTH-1:0] acc_r;
`endif

  // Operand A selection and iteration-unit launch decode.
  always_comb begin
    op_s = op_e'(ctrl);
`ifdef CALC_SEQ_ALU_ACC_EN
    if (acc_sel) begin
      a_s = acc_r;
    end else begin
      a_s = i1;
    end
`else
    a_s = i1;
`endif
    accept_s = in_valid && in_ready;
    is_div_s = (op_s == OP_DIV);
    if (accept_s && ((op_s == OP_MUL) || (is_div_s && (i2 != {WIDTH{1'b0}})))) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .is_div (is_div_s),
    .a      (a_s),
    .b      (i2),
    .done   (iter_done_s),
    .result (iter_result_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= {RW{1'b0}};
      neg       <= 1'b0;
      err       <= 1'b0;
`ifdef CALC_SEQ_ALU_ACC_EN
      acc_r     <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_ready <= 1'b0;
            neg      <= 1'b0;
            err      <= 1'b0;
            case (op_s)
              OP_ADD: begin
                o         <= {{WIDTH{1'b0}}, a_s} + {{WIDTH{1'b0}}, i2};
                out_valid <= 1'b1;
                state_r   <= DONE;
              end
              OP_SUB: begin
                o         <= {{WIDTH{1'b0}}, a_s} - {{WIDTH{1'b0}}, i2};
                neg       <= (a_s < i2);
                out_valid <= 1'b1;
                state_r   <= DONE;
              end
              OP_MUL: begin
                state_r <= CALC;
              end
              OP_DIV: begin
                if (i2 == {WIDTH{1'b0}}) begin
                  o         <= {RW{1'b1}};
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state_r   <= DONE;
                end else begin
                  state_r <= CALC;
                end
              end
              default: begin
                in_ready <= 1'b1;
                state_r  <= IDLE;
              end
            endcase
          end
        end
        CALC: begin
          if (iter_done_s) begin
            o         <= iter_result_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
`ifdef CALC_SEQ_ALU_ACC_EN
            acc_r     <= o[WIDTH-1:0];
`endif
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed self-checking bench for calc_seq_alu (WIDTH=4, or WIDTH=8 with
// CALC_SEQ_ALU_ACC_EN defined to exercise the accumulator operand).
module tb_calc_seq_alu;

`ifdef CALC_SEQ_ALU_ACC_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    ctrl = 2'b00;
  logic [W-1:0]  i1 = '0;
  logic [W-1:0]  i2 = '0;
  logic          in_ready;
  logic          out_valid;
  logic          neg;
  logic          err;
  logic [RW-1:0] o;
`ifdef CALC_SEQ_ALU_ACC_EN
  logic          acc_sel = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .i1        (i1),
    .i2        (i2),
`ifdef CALC_SEQ_ALU_ACC_EN
    .acc_sel   (acc_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .neg       (neg),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op, then count cycles until out_valid (accept edge counts as 1).
  task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic rdy_seen);
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = c;
    i1 = a;
    i2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl = ~c;
    i1 = ~a;
    i2 = ~b;
    lat = 1;
    rdy_seen = in_ready;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      rdy_seen = rdy_seen | in_ready;
    end
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  int   lat;
  logic rdy;
  logic stable;

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CALC_SEQ_ALU_ACC_EN
    run_op(2'b10, 8'd200, 8'd200, lat, rdy);
    check("mul8_o", 32'(o), 32'h9C40);
    check("mul8_lat", 32'(lat), 32'd9);
    check("mul8_in_ready_low", 32'(rdy), 32'd0);
    take_result("mul8");

    acc_sel = 1'b1;
    run_op(2'b00, 8'h55, 8'd1, lat, rdy);
    acc_sel = 1'b0;
    check("acc_add_o", 32'(o), 32'h0041);
    check("acc_add_lat", 32'(lat), 32'd1);
    take_result("acc_add");

    acc_sel = 1'b1;
    run_op(2'b01, 8'h00, 8'd2, lat, rdy);
    acc_sel = 1'b0;
    check("acc_sub_o", 32'(o), 32'h003F);
    check("acc_sub_neg", 32'(neg), 32'd0);
    take_result("acc_sub");

    run_op(2'b00, 8'd3, 8'd4, lat, rdy);
    check("noacc_add_o", 32'(o), 32'h0007);
    take_result("noacc_add");
`else
    run_op(2'b00, 4'd6, 4'd2, lat, rdy);
    check("add_o", 32'(o), 32'h08);
    check("add_lat", 32'(lat), 32'd1);
    check("add_neg", 32'(neg), 32'd0);
    take_result("add");

    run_op(2'b01, 4'd2, 4'd6, lat, rdy);
    check("sub_o", 32'(o), 32'hFC);
    check("sub_neg", 32'(neg), 32'd1);
    check("sub_lat", 32'(lat), 32'd1);
    take_result("sub");

    run_op(2'b00, 4'd15, 4'd15, lat, rdy);
    check("add_max_o", 32'(o), 32'h1E);
    check("add_neg_cleared", 32'(neg), 32'd0);
    take_result("add_max");

    run_op(2'b01, 4'd5, 4'd5, lat, rdy);
    check("sub_eq_o", 32'(o), 32'h00);
    check("sub_eq_neg", 32'(neg), 32'd0);
    take_result("sub_eq");

    run_op(2'b10, 4'd15, 4'd15, lat, rdy);
    check("mul_o", 32'(o), 32'hE1);
    check("mul_lat", 32'(lat), 32'd5);
    check("mul_in_ready_low", 32'(rdy), 32'd0);
    take_result("mul");

    run_op(2'b11, 4'd13, 4'd4, lat, rdy);
    check("div_o", 32'(o), 32'h13);
    check("div_lat", 32'(lat), 32'd5);
    check("div_err", 32'(err), 32'd0);
    take_result("div");

    run_op(2'b11, 4'd7, 4'd0, lat, rdy);
    check("div0_o", 32'(o), 32'hFF);
    check("div0_err", 32'(err), 32'd1);
    check("div0_lat", 32'(lat), 32'd1);
    take_result("div0");

    run_op(2'b11, 4'd7, 4'd7, lat, rdy);
    check("div_eq_o", 32'(o), 32'h01);
    check("div_eq_err", 32'(err), 32'd0);
    take_result("div_eq");

    run_op(2'b11, 4'd3, 4'd9, lat, rdy);
    check("div_small_o", 32'(o), 32'h30);
    take_result("div_small");

    // Backpressure: result must hold while new requests are ignored.
    run_op(2'b10, 4'd6, 4'd2, lat, rdy);
    check("bp_mul_o", 32'(o), 32'h0C);
    check("bp_mul_lat", 32'(lat), 32'd5);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ctrl = 2'b00;
      i1 = 4'd1;
      i2 = 4'd1;
      @(posedge clk);
      #1;
      stable = stable & (o == 8'h0C) & out_valid & ~in_ready & ~neg & ~err;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_stable", 32'(stable), 32'd1);
    take_result("bp");
    check("bp_o_kept", 32'(o), 32'h0C);

    // Reset during the second CALC cycle of a divide.
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 2'b11;
    i1 = 4'd13;
    i2 = 4'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_o", 32'(o), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stable = stable & ~out_valid;
    end
    check("abort_no_result", 32'(stable), 32'd1);
    run_op(2'b00, 4'd6, 4'd2, lat, rdy);
    check("post_abort_o", 32'(o), 32'h08);
    check("post_abort_lat", 32'(lat), 32'd1);
    take_result("post_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
